// File: rtl/alu_result_writeback.sv
// ALU result writeback: buffers 33-bit ALU results in a small FIFO and serialises
// each into one (narrow) or two (wide) 16-bit register-file writes, maintaining
// carry/zero/negative flags.
// Optional build macro WB_R0_ZERO_EN: suppress every write that targets address 0.
module alu_result_writeback #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [32:0]   res_data,
  input  logic          res_wide,
  input  logic [AW-1:0] res_dest,
  input  logic          rf_busy,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [15:0]   rf_wdata,
  output logic          flag_c,
  output logic          flag_z,
  output logic          flag_n,
  output logic          wb_idle
);

  localparam int unsigned PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);

`ifdef WB_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLo   = 2'd1;
  localparam logic [1:0] StHi   = 2'd2;

  // FIFO storage, one field per array
  logic [15:0]   lo_mem   [DEPTH];
  logic [15:0]   hi_mem   [DEPTH];
  logic          c_mem    [DEPTH];
  logic          wide_mem [DEPTH];
  logic [AW-1:0] dest_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic          hi_pend_q, hi_pend_d;  // LO of a wide entry issued, HI still owed
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [15:0]   rf_wdata_q, rf_wdata_d;
  logic          flag_c_q, flag_c_d;
  logic          flag_z_q, flag_z_d;
  logic          flag_n_q, flag_n_d;

  logic          push, pop;
  logic          go_lo, go_hi;
  logic [15:0]   h_lo, h_hi;
  logic          h_c, h_wide;
  logic [AW-1:0] h_dest, h_hi_addr;

  assign res_ready = (count_q < CntFull);
  assign push      = res_valid && res_ready;
  assign wb_idle   = (count_q == '0) && (state_q == StIdle);

  assign h_lo      = lo_mem[rd_ptr_q];
  assign h_hi      = hi_mem[rd_ptr_q];
  assign h_c       = c_mem[rd_ptr_q];
  assign h_wide    = wide_mem[rd_ptr_q];
  assign h_dest    = dest_mem[rd_ptr_q];
  assign h_hi_addr = h_dest + AW'(1);

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign flag_c   = flag_c_q;
  assign flag_z   = flag_z_q;
  assign flag_n   = flag_n_q;

  // Decide which write (if any) to issue at the next edge
  always_comb begin
    go_lo   = 1'b0;
    go_hi   = 1'b0;
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if ((count_q != '0) && !rf_busy) go_lo = 1'b1;
      end
      StLo: begin
        if (hi_pend_q) begin
          // Stall in LO with the write strobe dropped until the port frees up
          if (!rf_busy) go_hi = 1'b1;
        end else if ((count_q != '0) && !rf_busy) begin
          go_lo = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StHi: begin
        if ((count_q != '0) && !rf_busy) go_lo = 1'b1;
        else                             state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (go_lo) state_d = StLo;
    if (go_hi) state_d = StHi;
  end

  // Registered write port, flags and pop strobe; pop coincides with the last write issued
  always_comb begin
    pop        = 1'b0;
    hi_pend_d  = hi_pend_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    flag_c_d   = flag_c_q;
    flag_z_d   = flag_z_q;
    flag_n_d   = flag_n_q;
    if (go_lo) begin
      rf_we_d    = !(R0Zero && (h_dest == '0));
      rf_waddr_d = h_dest;
      rf_wdata_d = h_lo;
      flag_c_d   = h_c;
      flag_z_d   = h_wide ? ({h_hi, h_lo} == 32'd0) : (h_lo == 16'd0);
      flag_n_d   = h_wide ? h_hi[15] : h_lo[15];
      hi_pend_d  = h_wide;
      pop        = !h_wide;
    end else if (go_hi) begin
      rf_we_d    = !(R0Zero && (h_hi_addr == '0));
      rf_waddr_d = h_hi_addr;
      rf_wdata_d = h_hi;
      hi_pend_d  = 1'b0;
      pop        = 1'b1;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State, pointers and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      hi_pend_q  <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      flag_c_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      hi_pend_q  <= hi_pend_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      flag_c_q   <= flag_c_d;
      flag_z_q   <= flag_z_d;
      flag_n_q   <= flag_n_d;
    end
  end

  // FIFO payload capture; contents are don't-care until count covers them
  always_ff @(posedge clk) begin
    if (push) begin
      lo_mem[wr_ptr_q]   <= res_data[15:0];
      hi_mem[wr_ptr_q]   <= res_data[31:16];
      c_mem[wr_ptr_q]    <= res_data[32];
      wide_mem[wr_ptr_q] <= res_wide;
      dest_mem[wr_ptr_q] <= res_dest;
    end
  end

endmodule

// File: tb/tb_alu_result_writeback.sv
// Self-checking bench for alu_result_writeback: scoreboard of expected register
// writes filled on accepted handshakes and drained by a write monitor.
module tb_alu_result_writeback;

  localparam int unsigned AW = 4;

`ifdef WB_R0_ZERO_EN
  localparam bit R0Zero = 1'b1;
`else
  localparam bit R0Zero = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          res_valid;
  logic          res_ready;
  logic [32:0]   res_data;
  logic          res_wide;
  logic [AW-1:0] res_dest;
  logic          rf_busy;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [15:0]   rf_wdata;
  logic          flag_c, flag_z, flag_n;
  logic          wb_idle;

  always #5 clk = ~clk;

  alu_result_writeback #(
    .DEPTH (2),
    .AW    (AW)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_wide  (res_wide),
    .res_dest  (res_dest),
    .rf_busy   (rf_busy),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .wb_idle   (wb_idle)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic          lo;
    logic [2:0]    flg;   // {c, z, n} expected after a LO write
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_flags(input logic [32:0] d, input logic w);
    logic c, z, n;
    c = d[32];
    z = w ? (d[31:0] == 32'd0) : (d[15:0] == 16'd0);
    n = w ? d[31] : d[15];
    return {c, z, n};
  endfunction

  task automatic sb_push(input logic [32:0] d, input logic w, input logic [AW-1:0] dst);
    exp_t e;
    logic [AW-1:0] hi_a;
    e.addr = dst;
    e.data = d[15:0];
    e.lo   = 1'b1;
    e.flg  = model_flags(d, w);
    if (!(R0Zero && dst == '0)) exp_q.push_back(e);
    if (w) begin
      hi_a   = dst + AW'(1);
      e.addr = hi_a;
      e.data = d[31:16];
      e.lo   = 1'b0;
      e.flg  = 3'b000;
      if (!(R0Zero && hi_a == '0)) exp_q.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic send(input logic [32:0] d, input logic w, input logic [AW-1:0] dst);
    bit acc;
    int waits;
    acc   = 1'b0;
    waits = 0;
    res_valid = 1'b1;
    res_data  = d;
    res_wide  = w;
    res_dest  = dst;
    while (!acc && waits < 64) begin
      acc = res_ready;
      @(posedge clk);
      if (acc) sb_push(d, w, dst);
      else     @(negedge clk);
      waits++;
    end
    check_eq("accept", 32'(acc), 32'd1);
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (!wb_idle && i < 100) begin
      @(negedge clk);
      i++;
    end
    check_eq("idle_timeout", 32'(wb_idle), 32'd1);
  endtask

  // Every presented write must match the head of the scoreboard
  always @(negedge clk) begin
    if (rf_we) begin
      check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("waddr", 32'(rf_waddr), 32'(mon_e.addr));
        check_eq("wdata", 32'(rf_wdata), 32'(mon_e.data));
        if (mon_e.lo) check_eq("flags", 32'({flag_c, flag_z, flag_n}), 32'(mon_e.flg));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int i;
    rst_n     = 1'b0;
    res_valid = 1'b0;
    res_data  = '0;
    res_wide  = 1'b0;
    res_dest  = '0;
    rf_busy   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_we",    32'(rf_we), 32'd0);
    check_eq("rst_waddr", 32'(rf_waddr), 32'd0);
    check_eq("rst_wdata", 32'(rf_wdata), 32'd0);
    check_eq("rst_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
    check_eq("rst_idle",  32'(wb_idle), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(res_ready), 32'd1);

    // Narrow write latency and idle return
    send(33'h0_0000_1E00, 1'b0, 4'd3);
    check_eq("narrow_pre_we", 32'(rf_we), 32'd0);
    @(negedge clk);
    check_eq("narrow_we",    32'(rf_we), 32'd1);
    check_eq("narrow_waddr", 32'(rf_waddr), 32'd3);
    check_eq("narrow_wdata", 32'(rf_wdata), 32'h1E00);
    check_eq("narrow_busy",  32'(wb_idle), 32'd0);
    @(negedge clk);
    check_eq("narrow_post_we", 32'(rf_we), 32'd0);
    check_eq("narrow_idle",    32'(wb_idle), 32'd1);

    // Wide write: LO then HI on consecutive cycles
    send(33'h0_1234_5678, 1'b1, 4'd4);
    @(negedge clk);
    check_eq("wide_lo_we",   32'(rf_we), 32'd1);
    check_eq("wide_lo_addr", 32'(rf_waddr), 32'd4);
    @(negedge clk);
    check_eq("wide_hi_we",   32'(rf_we), 32'd1);
    check_eq("wide_hi_addr", 32'(rf_waddr), 32'd5);
    check_eq("wide_hi_data", 32'(rf_wdata), 32'h1234);
    @(negedge clk);
    check_eq("wide_done_we", 32'(rf_we), 32'd0);

    // Wide to register 15: HI wraps to register 0
    send(33'h0_0000_9ABC, 1'b1, 4'd15);
    @(negedge clk);
    check_eq("wrap_lo_addr", 32'(rf_waddr), 32'd15);
    @(negedge clk);
    check_eq("wrap_hi_we", 32'(rf_we), R0Zero ? 32'd0 : 32'd1);
    wait_idle();

    // Flag encodings
    send(33'h1_0000_0000, 1'b0, 4'd1);
    send(33'h0_FFAA_8000, 1'b1, 4'd2);
    wait_idle();
    check_eq("flags_last", 32'({flag_c, flag_z, flag_n}), 32'b001);

    // Backpressure: third result held while two are buffered and the port is busy
    rf_busy = 1'b1;
    fork
      begin
        send(33'h0_0000_0A0A, 1'b0, 4'd8);
        send(33'h0_0000_0000, 1'b0, 4'd9);
        send(33'h1_0000_C0C0, 1'b0, 4'd10);
      end
      begin
        repeat (3) @(negedge clk);
        check_eq("bp_ready", 32'(res_ready), 32'd0);
        check_eq("bp_we",    32'(rf_we), 32'd0);
        check_eq("bp_idle",  32'(wb_idle), 32'd0);
        rf_busy = 1'b0;
      end
    join
    wait_idle();
    check_eq("bp_drain", 32'(exp_q.size()), 32'd0);

    // Stall between LO and HI halves
    send(33'h0_BEEF_0001, 1'b1, 4'd11);
    @(negedge clk);
    check_eq("stall_lo_we",   32'(rf_we), 32'd1);
    check_eq("stall_lo_addr", 32'(rf_waddr), 32'd11);
    rf_busy = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("stall_we", 32'(rf_we), 32'd0);
    end
    rf_busy = 1'b0;
    @(negedge clk);
    check_eq("stall_hi_we",   32'(rf_we), 32'd1);
    check_eq("stall_hi_addr", 32'(rf_waddr), 32'd12);
    check_eq("stall_hi_data", 32'(rf_wdata), 32'hBEEF);
    @(negedge clk);
    check_eq("stall_done_we", 32'(rf_we), 32'd0);
    wait_idle();

    // Reset while the HI half is on the port, with another entry still buffered
    send(33'h0_CAFE_F00D, 1'b1, 4'd6);
    send(33'h0_0000_0077, 1'b0, 4'd9);
    i = 0;
    while (!(rf_we && rf_wdata == 16'hCAFE) && i < 20) begin
      @(negedge clk);
      i++;
    end
    check_eq("rstmid_hi_seen", 32'(rf_wdata), 32'hCAFE);
    rst_n = 1'b0;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    check_eq("rstmid_we",    32'(rf_we), 32'd0);
    check_eq("rstmid_idle",  32'(wb_idle), 32'd1);
    check_eq("rstmid_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rstmid_quiet_we", 32'(rf_we), 32'd0);
    check_eq("rstmid_ready",    32'(res_ready), 32'd1);

    // Narrow write to register 0
    send(33'h1_0000_8001, 1'b0, 4'd0);
    @(negedge clk);
    check_eq("r0_we",    32'(rf_we), R0Zero ? 32'd0 : 32'd1);
    check_eq("r0_flags", 32'({flag_c, flag_z, flag_n}), 32'b101);
    wait_idle();
    check_eq("final_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Consumer end of the ALU result interface. Accepts 33-bit ALU results (including wide multiply products) through a valid/ready handshake and buffers them in a small FIFO.
- Serialises each result into 16-bit register-file writes: one write for narrow ops, two for wide ops.
- Sits between the EX stage ALU and the register-file write port, and maintains the carry/zero/negative flags.

Parameters:
- DEPTH, 2, FIFO entries (power of two, >=2)
- AW, 4, register address width (16 registers)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- res_valid  in  1  ALU result valid
- res_ready  out  1  block can accept a result this cycle
- res_data  in  33  ALU result; [15:0] lo, [31:16] hi, [32] carry
- res_wide  in  1  1 = wide op (multiply): write hi as well
- res_dest  in  AW  destination register
- rf_busy  in  1  register-file port unavailable this cycle
- rf_we  out  1  register write enable
- rf_waddr  out  AW  register write address
- rf_wdata  out  16  register write data
- flag_c  out  1  carry flag
- flag_z  out  1  zero flag
- flag_n  out  1  negative flag
- wb_idle  out  1  FIFO empty and FSM idle

Behaviour:
- Reset (rst_n low at a clk edge):
  - rf_we=0, rf_waddr=0, rf_wdata=0, flags=0, FIFO count=0, state=IDLE.
  - wb_idle=1. res_ready=1 in the cycle after reset releases.
  - Reset mid-operation discards all buffered entries and any pending hi write; no partial write completes.
- Handshake:
  - res_ready = (count < DEPTH), combinational from registered count.
  - Transfer occurs when res_valid && res_ready at the clk edge.
  - res_data/res_dest/res_wide are sampled only on transfer.
  - res_valid with res_ready=0 is ignored; the producer holds.
- FIFO:
  - Circular, with pointer wrap at DEPTH.
  - Push and pop in the same cycle leaves count unchanged.
  - Pop occurs on the edge that issues the last write of the head entry (LO for narrow, HI for wide).
  - When full, a same-cycle pop does not enable a push: ready is based on count before the edge.
- FSM states:
  - IDLE: if count>0 and !rf_busy -> LO; else stay.
  - LO: rf_we=1, rf_waddr=dest, rf_wdata=lo. If wide -> HI; else pop, then LO if another entry remains and !rf_busy, otherwise IDLE.
  - HI: rf_we=1, rf_waddr=dest+1 (mod 2^AW, so 15 wraps to 0), rf_wdata=hi. Pop, then next as from LO.
  - Outputs are registered. A write is presented for exactly one cycle per state visit.
- rf_busy:
  - Sampled at each edge that would start the next write.
  - While rf_busy=1 the FSM stalls before LO or HI and rf_we=0.
  - A wide result may stall between its LO and HI writes; the HI write then occurs after rf_busy drops.
- Latency:
  - Result accepted at edge N with empty FIFO and rf_busy=0: rf_we high for LO during cycle N+1, HI during N+2.
  - Back-to-back narrow results sustain one write per cycle.
- Flags (updated on the edge entering LO only):
  - flag_c = res_data[32].
  - flag_z: narrow = (lo==0); wide = ({hi,lo}==0).
  - flag_n: narrow = lo[15]; wide = hi[15].
- wb_idle = (count==0) && state==IDLE.

Optional Feature:
- WB_R0_ZERO_EN
- Defined: any write targeting address 0 (LO or HI, including HI wrap 15->0) keeps rf_we=0. The state still advances, pops and updates flags normally.
- Undefined: address 0 is written like any other register.

Test Plan:
- Narrow: res_data=0x0_0000_1E00, wide=0, dest=3 -> next cycle rf_we=1, waddr=3, wdata=0x1E00; flags c=0, z=0, n=0; wb_idle=1 the cycle after.
- Wide: res_data=0x0_1234_5678, wide=1, dest=4 -> waddr=4/0x5678, then waddr=5/0x1234 on consecutive cycles. Repeat with dest=15 -> HI to waddr=0.
- Flags: res_data=0x1_0000_0000 narrow -> c=1, z=1, n=0. res_data=0x0_FFAA_8000 wide -> c=0, z=0, n=1.
- Backpressure: push 3 narrow results back-to-back with rf_busy=1 (DEPTH=2) -> res_ready low after 2 accepted, third held. Release rf_busy -> 3 writes in order, third accepted once a slot frees.
- Stall between halves: wide result with rf_busy raised after LO for 3 cycles -> HI write appears exactly 1 cycle after rf_busy drops, no duplicate LO.
- Reset mid-wide: assert rst_n=0 during HI state -> rf_we=0 next cycle, FIFO empty, wb_idle=1. With WB_R0_ZERO_EN, narrow dest=0 -> rf_we stays 0, flags still update.
